// File: rtl/uart_port_sched.sv
// rtl/uart_port_sched.sv - transmit arbiter and receive sequencer for the Rs232RefComp UART core
//
// Purpose:
//   Shares the core's single transmit path between two byte-stream requesters.
//   Both requesters use a valid/ready handshake, and the arbiter alternates
//   between them in round-robin order. On the receive side the block drives the
//   core's RD strobe and delivers each received byte as a one-cycle rx_valid
//   pulse together with its error flags.
//
// Optional build macro:
//   UART_SCHED_ERR_CNT_EN - when defined, the block keeps saturating pe/fe/oe
//   error counters and a receive-byte counter. When undefined, the four counter
//   outputs are tied to 0.
//
// Ports:
//   clk, RST                         system clock (50 MHz) and sync active-high reset
//   req0_valid/req0_data/req0_ready  requester 0 byte handshake
//   req1_valid/req1_data/req1_ready  requester 1 byte handshake
//   uart_dbin, uart_wr, uart_tbe     core transmit interface
//   uart_dbout, uart_rd, uart_rda    core receive interface
//   uart_pe, uart_fe, uart_oe        core receive error flags
//   rx_valid, rx_data, rx_err        received byte pulse, data, {pe,fe,oe}
//   tx_busy, tx_grant, tx_timeout    TX status: busy, last granted id, sticky TBE timeout
//   pe_cnt, fe_cnt, oe_cnt, rx_cnt   saturating counters (macro-dependent)

module uart_port_sched #(
    parameter int TBE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [7:0]  uart_dbin,
    output logic        uart_wr,
    input  logic        uart_tbe,
    input  logic [7:0]  uart_dbout,
    output logic        uart_rd,
    input  logic        uart_rda,
    input  logic        uart_pe,
    input  logic        uart_fe,
    input  logic        uart_oe,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rx_err,
    output logic        tx_busy,
    output logic        tx_grant,
    output logic        tx_timeout,
    output logic [15:0] pe_cnt,
    output logic [15:0] fe_cnt,
    output logic [15:0] oe_cnt,
    output logic [15:0] rx_cnt
);

    localparam logic [15:0] TBE_LIMIT = 16'(TBE_TIMEOUT - 1);

    typedef enum logic [1:0] {T_IDLE, T_WR, T_WAIT_BUSY, T_WAIT_EMPTY} txState_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rxState_t;

    txState_t    txState, txNext;
    rxState_t    rxState, rxNext;
    logic [15:0] tbeCnt;
    logic        winnerId;
    logic        txAccept;

    // Round-robin pick: on contention the requester that did not win last time
    // goes next; otherwise the single valid requester is chosen.
    always_comb begin
        winnerId   = (req0_valid && req1_valid) ? ~tx_grant : req1_valid;
        req0_ready = (txState == T_IDLE) && uart_tbe && req0_valid && !winnerId;
        req1_ready = (txState == T_IDLE) && uart_tbe && req1_valid && winnerId;
        txAccept   = req0_ready || req1_ready;
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (RST) txState <= T_IDLE;
        else     txState <= txNext;
    end

    // TX next state
    always_comb begin
        txNext = txState;
        case (txState)
            T_IDLE:       if (txAccept) txNext = T_WR;
            T_WR:         txNext = T_WAIT_BUSY;
            // Either the core starts shifting (TBE falls), or the core never
            // acknowledged the write and we stop waiting so the port cannot lock up.
            T_WAIT_BUSY:  if (!uart_tbe || tbeCnt == TBE_LIMIT) txNext = T_WAIT_EMPTY;
            T_WAIT_EMPTY: if (uart_tbe) txNext = T_IDLE;
            default:      txNext = T_IDLE;
        endcase
    end

    // TX outputs
    always_comb begin
        uart_wr = (txState == T_WR);
        tx_busy = (txState != T_IDLE);
    end

    // TX datapath: captured byte, grant history, timeout counter and flag
    always_ff @(posedge clk) begin
        if (RST) begin
            uart_dbin  <= 8'h00;
            tx_grant   <= 1'b1;
            tx_timeout <= 1'b0;
            tbeCnt     <= 16'h0000;
        end else begin
            if (txAccept) begin
                uart_dbin <= winnerId ? req1_data : req0_data;
                tx_grant  <= winnerId;
            end
            if (txState == T_WR) begin
                tbeCnt <= 16'h0000;
            end else if (txState == T_WAIT_BUSY && uart_tbe) begin
                if (tbeCnt == TBE_LIMIT) tx_timeout <= 1'b1;
                else                     tbeCnt <= tbeCnt + 16'd1;
            end
        end
    end

    // RX state register; reset lands in R_WAIT so RD stays high and flushes
    // any stale byte held by the core.
    always_ff @(posedge clk) begin
        if (RST) rxState <= R_WAIT;
        else     rxState <= rxNext;
    end

    // RX next state
    always_comb begin
        rxNext = rxState;
        case (rxState)
            R_IDLE:  if (uart_rda) rxNext = R_ACK;
            R_ACK:   rxNext = R_WAIT;
            R_WAIT:  if (!uart_rda) rxNext = R_IDLE;
            default: rxNext = R_WAIT;
        endcase
    end

    // RX outputs
    always_comb begin
        uart_rd  = (rxState != R_IDLE);
        rx_valid = (rxState == R_ACK);
    end

    // RX capture
    always_ff @(posedge clk) begin
        if (RST) begin
            rx_data <= 8'h00;
            rx_err  <= 3'b000;
        end else if (rxState == R_IDLE && uart_rda) begin
            rx_data <= uart_dbout;
            rx_err  <= {uart_pe, uart_fe, uart_oe};
        end
    end

`ifdef UART_SCHED_ERR_CNT_EN
    logic [15:0] peCnt, feCnt, oeCnt, rxCnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            peCnt <= 16'h0000;
            feCnt <= 16'h0000;
            oeCnt <= 16'h0000;
            rxCnt <= 16'h0000;
        end else if (rxState == R_ACK) begin
            if (rx_err[2] && peCnt != 16'hFFFF) peCnt <= peCnt + 16'd1;
            if (rx_err[1] && feCnt != 16'hFFFF) feCnt <= feCnt + 16'd1;
            if (rx_err[0] && oeCnt != 16'hFFFF) oeCnt <= oeCnt + 16'd1;
            if (rxCnt != 16'hFFFF)              rxCnt <= rxCnt + 16'd1;
        end
    end

    assign pe_cnt = peCnt;
    assign fe_cnt = feCnt;
    assign oe_cnt = oeCnt;
    assign rx_cnt = rxCnt;
`else
    assign pe_cnt = 16'h0000;
    assign fe_cnt = 16'h0000;
    assign oe_cnt = 16'h0000;
    assign rx_cnt = 16'h0000;
`endif

endmodule
